core_issue_ctrl: RTL

//  Issue sequencer between fetch and core_decoder. Buffers fetched instructions in a 2-entry queue.

---
 rtl/core_pkg.sv | 61 ++++++
 rtl/core_scoreboard.sv | 72 +++++++
 rtl/core_issue_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and decode helpers for the core front end: opcodes, issue-queue
// occupancy states, the queued beat payload and scoreboard sizing defaults.
package core_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned NUM_REGS_DEFAULT = 32;
    localparam int unsigned SB_CNT_W_DEFAULT = 2;

    typedef enum logic [6:0] {
        LOAD   = 7'h03,
        OP_IMM = 7'h13,
        AUIPC  = 7'h17,
        STORE  = 7'h23,
        OP     = 7'h33,
        LUI    = 7'h37,
        BRANCH = 7'h63,
        JALR   = 7'h67,
        JAL    = 7'h6F
    } opcode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } issue_entry_t;

    function automatic logic uses_rs1(opcode_e op);
        logic r;
        case (op)
            OP, OP_IMM, LOAD, STORE, BRANCH, JALR: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2(opcode_e op);
        logic r;
        case (op)
            OP, STORE, BRANCH: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    // rd == x0 is filtered by the caller; this only classifies the opcode.
    function automatic logic writes_rd(opcode_e op);
        logic r;
        case (op)
            OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR: r = 1'b1;
            default:                                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/core_scoreboard.sv
// Per-register pending-write counters. x0 is never tracked; a same-cycle
// increment and decrement of one register cancel out.
module core_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned SB_CNT_W = SB_CNT_W_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  inc_en_i,
    input  logic [REG_ADDR_W-1:0] inc_addr_i,
    input  logic                  dec_en_i,
    input  logic [REG_ADDR_W-1:0] dec_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rd_sat_o,
    output logic                  any_busy_o
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];

    logic inc_c, dec_c, same_c, dec_underflow_c;

    assign inc_c  = inc_en_i && (inc_addr_i != '0);
    assign dec_c  = dec_en_i && (dec_addr_i != '0);
    assign same_c = inc_c && dec_c && (inc_addr_i == dec_addr_i);

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0 && !same_c) begin
                if (inc_c && inc_addr_i == REG_ADDR_W'(r) && cnt_q[r] != CNT_MAX) begin
                    cnt_d[r] = cnt_q[r] + SB_CNT_W'(1);
                end else if (dec_c && dec_addr_i == REG_ADDR_W'(r) && cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - SB_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_comb begin
        any_busy_o = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            any_busy_o = any_busy_o | (cnt_q[r] != '0);
        end
    end

    assign rs1_busy_o = (rs1_addr_i != '0) && (cnt_q[rs1_addr_i] != '0);
    assign rs2_busy_o = (rs2_addr_i != '0) && (cnt_q[rs2_addr_i] != '0);
    assign rd_sat_o   = (rd_addr_i  != '0) && (cnt_q[rd_addr_i] == CNT_MAX);

    // A retirement with no pending write means the pipeline lost track of a writer.
    assign dec_underflow_c = dec_c && !same_c && (cnt_q[dec_addr_i] == '0);

    a_no_dec_underflow: assert property (@(posedge clk_i) disable iff (arst_i) !dec_underflow_c);

endmodule

// File: rtl/core_issue_ctrl.sv
// Issue sequencer: 2-entry in-order queue between fetch and decode, holding the
// head on RAW hazards or backpressure, and discarding queued beats on flush.
module core_issue_ctrl
    import core_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned SB_CNT_W = SB_CNT_W_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  instr_valid_i,
    input  logic [XLEN-1:0]       instr_i,
    input  logic [XLEN-1:0]       pc_i,
    output logic                  instr_ready_o,
    output logic                  dec_valid_o,
    output logic [XLEN-1:0]       dec_instr_o,
    output logic [XLEN-1:0]       dec_pc_o,
    input  logic                  dec_ready_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o
);

    issue_state_e state_q, state_d;
    issue_entry_t head_q, head_d, tail_q, tail_d;
    issue_entry_t beat_c;

    logic                  push_c, pop_c, head_valid_c, hazard_c, head_wr_rd_c;
    opcode_e               head_op_c;
    logic [REG_ADDR_W-1:0] rs1_c, rs2_c, rd_c;
    logic                  rs1_busy_c, rs2_busy_c, rd_sat_c, sb_busy_c;

    assign beat_c       = {instr_i, pc_i};
    assign head_op_c    = opcode_e'(head_q.instr[6:0]);
    assign rd_c         = head_q.instr[11:7];
    assign rs1_c        = head_q.instr[19:15];
    assign rs2_c        = head_q.instr[24:20];
    assign head_wr_rd_c = writes_rd(head_op_c) && (rd_c != '0);

    assign push_c = instr_valid_i && instr_ready_o && !flush_i;
    assign pop_c  = dec_valid_o && dec_ready_i;

    // Outputs depend on state and current-cycle hazard/flush, never on queue contents beyond the head.
    always_comb begin
        instr_ready_o = (state_q != FULL);
        head_valid_c  = (state_q != EMPTY);
        hazard_c      = head_valid_c && ((uses_rs1(head_op_c) && rs1_busy_c) ||
                                         (uses_rs2(head_op_c) && rs2_busy_c) ||
                                         (head_wr_rd_c && rd_sat_c));
        dec_valid_o   = head_valid_c && !hazard_c && !flush_i;
        stall_o       = head_valid_c && !flush_i && (hazard_c || !dec_ready_i);
        busy_o        = sb_busy_c || head_valid_c;
        dec_instr_o   = head_q.instr;
        dec_pc_o      = head_q.pc;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push_c) begin
                        head_d  = beat_c;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (push_c && pop_c) begin
                        head_d = beat_c;
                    end else if (push_c) begin
                        tail_d  = beat_c;
                        state_d = FULL;
                    end else if (pop_c) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop_c) begin
                        head_d  = tail_q;
                        state_d = HALF;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    core_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .SB_CNT_W (SB_CNT_W)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .inc_en_i   (pop_c && head_wr_rd_c),
        .inc_addr_i (rd_c),
        .dec_en_i   (wb_valid_i),
        .dec_addr_i (wb_rd_addr_i),
        .rs1_addr_i (rs1_c),
        .rs2_addr_i (rs2_c),
        .rd_addr_i  (rd_c),
        .rs1_busy_o (rs1_busy_c),
        .rs2_busy_o (rs2_busy_c),
        .rd_sat_o   (rd_sat_c),
        .any_busy_o (sb_busy_c)
    );

endmodule
